// File: rtl/systolic_result_collector_pkg.sv
`default_nettype none
// =============================================================================
// Module      : systolic_pkg
// Description : Shared types, defaults and the ReLU/shift/saturate helper
//               for the systolic array readout path.
// Revision    : 1.0 - initial release
// =============================================================================
package systolic_pkg;

    localparam int c_NUM_PE = 8;
    localparam int c_ACC_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        TAIL   = 2'd2,
        STREAM = 2'd3
    } collector_state_t;

    // Works on a sign-extended 32-bit value so callers of any width up to 32
    // can share it; the caller truncates the result to its output width.
    function automatic logic signed [31:0] relu_shift_sat(
        input logic signed [31:0] v,
        input int                 shift,
        input int                 out_w,
        input logic               relu
    );
        logic signed [31:0] t;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        t  = (relu && (v < 0)) ? 32'sd0 : v;
        t  = t >>> shift;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (t > hi) begin
            return hi;
        end
        if (t < lo) begin
            return lo;
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_result_collector_postproc.sv
`default_nettype none
// =============================================================================
// Module      : result_postproc
// Description : Combinational ReLU, arithmetic shift and saturation of one
//               accumulator value.
// Revision    : 1.0 - initial release
// =============================================================================
module result_postproc
    import systolic_pkg::*;
#(
    parameter int ACC_W   = c_ACC_W,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 0,
    parameter int RELU_EN = 1
) (
    input  logic [ACC_W-1:0] i_acc,
    output logic [OUT_W-1:0] o_data
);

    logic signed [31:0] w_ext;
    logic signed [31:0] w_res;

    always_comb begin
        w_ext  = 32'(signed'(i_acc));
        w_res  = relu_shift_sat(w_ext, SHIFT, OUT_W, RELU_EN != 0);
        o_data = OUT_W'(w_res);
    end

endmodule
`default_nettype wire

// File: rtl/systolic_result_collector.sv
`default_nettype none
// =============================================================================
// Module      : systolic_result_collector
// Description : Sweeps drain_sel over the PE array, post-processes each
//               accumulator into a buffer and streams it out valid/ready.
// Revision    : 1.0 - initial release
// =============================================================================
module systolic_result_collector
    import systolic_pkg::*;
#(
    parameter int NUM_PE  = c_NUM_PE,
    parameter int ACC_W   = c_ACC_W,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 0,
    parameter int RELU_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      drain_start,
    output logic [$clog2(NUM_PE)-1:0] drain_sel,
    input  logic [ACC_W-1:0]          acc_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [$clog2(NUM_PE)-1:0] out_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      err_overrun,
    input  logic                      err_clr
);

    localparam int                 c_SEL_W = $clog2(NUM_PE);
    localparam logic [c_SEL_W-1:0] c_LAST  = c_SEL_W'(NUM_PE - 1);
    localparam logic [c_SEL_W-1:0] c_ONE   = c_SEL_W'(1);

    collector_state_t   r_state_q,   w_state_d;
    logic [c_SEL_W-1:0] r_sel_cnt_q, w_sel_cnt_d;
    logic [c_SEL_W-1:0] r_rd_ptr_q,  w_rd_ptr_d;
    logic [c_SEL_W-1:0] r_cap_idx_q, w_cap_idx_d;
    logic               r_cap_en_q,  w_cap_en_d;
    logic               r_done_q,    w_done_d;
    logic               r_err_q,     w_err_d;
    logic [OUT_W-1:0]   r_buf_q [NUM_PE];
    logic [OUT_W-1:0]   w_pp_data;
    logic               w_busy;
    logic               w_hs;

    result_postproc #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT),
        .RELU_EN (RELU_EN)
    ) u_postproc (
        .i_acc  (acc_in),
        .o_data (w_pp_data)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_sel_cnt_d = r_sel_cnt_q;
        w_rd_ptr_d  = r_rd_ptr_q;
        w_cap_idx_d = r_sel_cnt_q;
        w_cap_en_d  = 1'b0;
        w_done_d    = 1'b0;
        w_err_d     = r_err_q;
        w_busy      = (r_state_q != IDLE);
        w_hs        = (r_state_q == STREAM) && out_ready;

        case (r_state_q)
            IDLE: begin
                if (drain_start) begin
                    w_state_d   = SWEEP;
                    w_sel_cnt_d = '0;
                    w_rd_ptr_d  = '0;
                end
            end
            SWEEP: begin
                // Capture lags select by one cycle, matching the array's
                // registered final_acc_out.
                w_cap_en_d  = 1'b1;
                w_sel_cnt_d = r_sel_cnt_q + c_ONE;
                if (r_sel_cnt_q == c_LAST) begin
                    w_state_d   = TAIL;
                    w_sel_cnt_d = '0;
                end
            end
            TAIL: begin
                w_state_d = STREAM;
            end
            STREAM: begin
                if (w_hs) begin
                    w_rd_ptr_d = r_rd_ptr_q + c_ONE;
                    if (r_rd_ptr_q == c_LAST) begin
                        w_state_d = IDLE;
                        w_done_d  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // A new overrun in the same cycle as a clear must win.
        if (err_clr) begin
            w_err_d = 1'b0;
        end
        if (drain_start && w_busy) begin
            w_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_sel_cnt_q <= '0;
            r_rd_ptr_q  <= '0;
            r_cap_idx_q <= '0;
            r_cap_en_q  <= 1'b0;
            r_done_q    <= 1'b0;
            r_err_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_sel_cnt_q <= w_sel_cnt_d;
            r_rd_ptr_q  <= w_rd_ptr_d;
            r_cap_idx_q <= w_cap_idx_d;
            r_cap_en_q  <= w_cap_en_d;
            r_done_q    <= w_done_d;
            r_err_q     <= w_err_d;
        end
    end

    // Buffer contents are masked at the output, so they need no reset.
    always_ff @(posedge clk) begin
        if (r_cap_en_q) begin
            r_buf_q[r_cap_idx_q] <= w_pp_data;
        end
    end

    always_comb begin
        drain_sel   = (r_state_q == SWEEP) ? r_sel_cnt_q : '0;
        out_valid   = (r_state_q == STREAM);
        out_idx     = r_rd_ptr_q;
        out_data    = out_valid ? r_buf_q[r_rd_ptr_q] : '0;
        busy        = w_busy;
        done        = r_done_q;
        err_overrun = r_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_collector.sv
`default_nettype none
// =============================================================================
// Module      : tb_systolic_result_collector
// Description : Self-checking bench for the drain/post-process/stream path.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_systolic_result_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       drain_start;
    logic       out_ready;
    logic       err_clr;
    logic [7:0] acc_in;

    logic [2:0] drain_sel, out_idx;
    logic [7:0] out_data;
    logic       out_valid, busy, done, err_overrun;

    logic [2:0] sel_s1, idx_s1, sel_n, idx_n;
    logic [7:0] data_s1, data_n;
    logic       valid_s1, busy_s1, done_s1, err_s1;
    logic       valid_n, busy_n, done_n, err_n;

    always #5 clk = ~clk;

    systolic_result_collector dut (
        .clk(clk), .rst(rst), .drain_start(drain_start), .drain_sel(drain_sel),
        .acc_in(acc_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done),
        .err_overrun(err_overrun), .err_clr(err_clr)
    );

    systolic_result_collector #(.SHIFT(1), .RELU_EN(1)) dut_s1 (
        .clk(clk), .rst(rst), .drain_start(drain_start), .drain_sel(sel_s1),
        .acc_in(acc_in), .out_valid(valid_s1), .out_ready(out_ready),
        .out_data(data_s1), .out_idx(idx_s1), .busy(busy_s1), .done(done_s1),
        .err_overrun(err_s1), .err_clr(err_clr)
    );

    systolic_result_collector #(.SHIFT(1), .RELU_EN(0)) dut_n (
        .clk(clk), .rst(rst), .drain_start(drain_start), .drain_sel(sel_n),
        .acc_in(acc_in), .out_valid(valid_n), .out_ready(out_ready),
        .out_data(data_n), .out_idx(idx_n), .busy(busy_n), .done(done_n),
        .err_overrun(err_n), .err_clr(err_clr)
    );

    typedef struct {
        logic [2:0] idx;
        logic [7:0] data;
    } sb_t;

    typedef struct {
        logic [7:0] acc;
        logic [7:0] exp_s1;
        logic [7:0] exp_n;
    } vec_t;

    sb_t  sb[$];
    vec_t vec[8];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_pop   = 0;
    int   acc_mode = 0;
    logic err_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Array model: final_acc_out is registered one cycle after drain_sel.
    always @(posedge clk) begin
        case (acc_mode)
            0:       acc_in <= 8'(10 * drain_sel);
            1:       acc_in <= vec[drain_sel].acc;
            default: acc_in <= 8'($urandom);
        endcase
    end

    // Scoreboard: every valid cycle must present the oldest outstanding entry.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("out_idx", 32'(out_idx), 32'(sb[0].idx));
                check("out_data", 32'(out_data), 32'(sb[0].data));
                if (acc_mode == 1 && out_ready) begin
                    check("s1_idx", 32'(idx_s1), 32'(sb[0].idx));
                    check("s1_data", 32'(data_s1), 32'(vec[sb[0].idx].exp_s1));
                    check("norelu_valid", 32'(valid_n), 32'd1);
                    check("norelu_data", 32'(data_n), 32'(vec[sb[0].idx].exp_n));
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                    n_pop++;
                end
            end
        end
    end

    task automatic push_exp();
        logic signed [7:0] a;
        for (int i = 0; i < 8; i++) begin
            a = (acc_mode == 1) ? vec[i].acc : 8'(10 * i);
            sb.push_back('{idx: 3'(i), data: (a < 0) ? 8'd0 : a});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 drain_start = 1'b1;
        @(posedge clk); #1 drain_start = 1'b0;
    endtask

    // Full drain with out_ready high; cycle 0 is the drain_start cycle.
    task automatic timed_drain(input int extra1, input int extra2, input int clr_at);
        push_exp();
        pulse_start();
        for (int c = 1; c <= 18; c++) begin
            drain_start = (c == extra1) || (c == extra2);
            err_clr     = (c == clr_at);
            @(negedge clk);
            check("drain_sel", 32'(drain_sel), (c >= 1 && c <= 8) ? 32'(c - 1) : 32'd0);
            check("out_valid", 32'(out_valid), 32'(c >= 10 && c <= 17));
            check("done", 32'(done), 32'(c == 18));
            check("busy", 32'(busy), 32'(c <= 17));
            check("err_overrun", 32'(err_overrun), 32'(err_exp));
            @(posedge clk);
            if (err_clr) err_exp = 1'b0;
            if (drain_start && c <= 17) err_exp = 1'b1;
            #1;
        end
        drain_start = 1'b0;
        err_clr     = 1'b0;
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic bp_drain();
        bit seen = 1'b0;
        push_exp();
        pulse_start();
        for (int c = 1; c <= 80 && !seen; c++) begin
            out_ready = c[0];
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("bp_done_seen", 32'(seen), 32'd1);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int pop0;
        rst = 1'b1; drain_start = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        vec[0] = '{acc: 8'hFB, exp_s1: 8'd0,  exp_n: 8'hFD};
        vec[1] = '{acc: 8'd127, exp_s1: 8'd63, exp_n: 8'd63};
        vec[2] = '{acc: 8'd3,   exp_s1: 8'd1,  exp_n: 8'd1};
        vec[3] = '{acc: 8'h80,  exp_s1: 8'd0,  exp_n: 8'hC0};
        vec[4] = '{acc: 8'd1,   exp_s1: 8'd0,  exp_n: 8'd0};
        vec[5] = '{acc: 8'd0,   exp_s1: 8'd0,  exp_n: 8'd0};
        vec[6] = '{acc: 8'd100, exp_s1: 8'd50, exp_n: 8'd50};
        vec[7] = '{acc: 8'd64,  exp_s1: 8'd32, exp_n: 8'd32};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel", 32'(drain_sel), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_overrun), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        acc_mode = 0; timed_drain(0, 0, 0);
        acc_mode = 1; timed_drain(0, 0, 0);
        acc_mode = 0; bp_drain();

        // Overrun during SWEEP and in the final-handshake cycle.
        timed_drain(4, 17, 0);
        @(negedge clk);
        check("err_sticky", 32'(err_overrun), 32'd1);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0; err_exp = 1'b0;
        @(negedge clk);
        check("err_cleared", 32'(err_overrun), 32'd0);
        // Clear and new overrun together: set wins.
        timed_drain(3, 0, 3);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0; err_exp = 1'b0;

        // Reset after three accepted entries.
        push_exp();
        pop0 = n_pop;
        pulse_start();
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1; err_exp = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sel", 32'(drain_sel), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_pops", 32'(n_pop - pop0), 32'd3);
        sb.delete();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("mid_rst_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        timed_drain(0, 0, 0);

        // Idle stability with random array data.
        acc_mode = 2;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_sel", 32'(drain_sel), 32'd0);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
